full_logic_pop_scheduler: RTL and testbench
===========================================

// Module: full_logic_pop_scheduler
// PURPOSE
//  Drains the two destination FIFOs (D0, D1) of the full_logic datapath into one downstream stream.
//  Weighted round-robin arbitration chooses which FIFO to pop; popped words go through a 2-entry output buffer.
//  Output is a valid/ready stream. Lifecycle FSM: RESET/INIT/IDLE/ACTIVE/ERROR. Replaces manual D0_pop/D1_pop driving.
// PARAMETERS
//  DATA_WIDTH    6  width of FIFO words and out_data
//  WEIGHT_WIDTH  3  width of per-destination burst weights
// PORTS
//  clk            in   1            single clock, rising edge
//  reset          in   1            synchronous, active-high
//  init           in   1            1 = enter/hold INIT and load cfg weights
//  cfg_weight_d0  in   WEIGHT_WIDTH max consecutive D0 pops per turn; 0 = D0 disabled
//  cfg_weight_d1  in   WEIGHT_WIDTH max consecutive D1 pops per turn; 0 = D1 disabled
//  empty_d0       in   1            D0 FIFO empty; reflects pops up to the previous cycle
//  empty_d1       in   1            D1 FIFO empty
//  data_out_d0    in   DATA_WIDTH   D0 FIFO read data, valid the cycle after D0_pop
//  data_out_d1    in   DATA_WIDTH   D1 FIFO read data, valid the cycle after D1_pop
//  error_d0       in   1            D0 FIFO overflow/underflow
//  error_d1       in   1            D1 FIFO overflow/underflow
//  out_ready      in   1            downstream accepts out_data this cycle
//  D0_pop         out  1            pop D0 FIFO (combinational from registered state)
//  D1_pop         out  1            pop D1 FIFO
//  out_data       out  DATA_WIDTH   head word of output buffer
//  out_src        out  1            0 = head word came from D0, 1 = from D1
//  out_valid      out  1            output buffer non-empty
//  state          out  3            FSM state encoding
//  sched_error    out  1            1 while in ERROR
// BEHAVIOUR
//  - Reset value (at the edge with reset=1): state=RESET, buffer flushed, in-flight cleared, out_valid=0, out_data=0,
//    out_src=0, weights=1/1, grant=D0, burst_cnt=0. While reset=1, D0_pop and D1_pop are 0.
//  - State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
//  - RESET -> INIT on the first cycle with reset=0.
//  - INIT: each cycle with init=1, latch cfg weights. init=0 -> IDLE. If both latched weights are 0 -> ERROR instead.
//  - IDLE -> ACTIVE: when an enabled FIFO is non-empty.
//  - IDLE -> INIT: when init=1. In ACTIVE, init is ignored.
//  - ACTIVE -> IDLE: when both enabled FIFOs are empty, no pop is in flight, and the buffer is empty.
//  - Any state except RESET -> ERROR: when error_d0|error_d1 is sampled 1. ERROR is sticky until reset.
//    In ERROR: no pops, the buffer may still be drained by out_ready.
//  - Pop rule: pop allowed only in ACTIVE. At most one pop per cycle. Never pop an empty or disabled FIFO.
//    Let accept = out_valid & out_ready and inflight = pop issued in the previous cycle.
//    Pop only if (buf_count + inflight - accept) < 2.
//  - Latency: pop in cycle N -> word captured at end of N+1 -> out_valid/out_data in N+2. Sustained 1 word/cycle with out_ready=1.
//  - WRR arbitration: grant stays on the current FIFO until one of:
//    (a) burst_cnt reaches its weight, (b) that FIFO is empty, (c) that FIFO is disabled.
//    Then grant switches to the other FIFO and burst_cnt=0. If the other FIFO is empty, grant stays and burst_cnt resets.
//  - Buffer: FIFO order. out_data/out_src hold steady while out_valid=1 and out_ready=0.
//    Simultaneous capture and accept at count 2 cannot occur (guaranteed by the pop rule).
//  - Reset mid-operation: the in-flight word is discarded. FIFO contents are untouched.
// STRUCTURE
//  - full_logic_pkg: state localparams (RESET..ERROR), DATA_WIDTH/WEIGHT_WIDTH defaults, SRC_D0/SRC_D1 constants.
//  - Sub-module full_logic_skid2: 2-entry FIFO-ordered buffer {src,data}; ports push, pop, count, head.
//  - Top level holds the FSM, WRR grant/burst counter, in-flight flag, and pop logic.
// TESTING
//  1. reset=1 for 2 cycles -> all outputs 0, state=0. Release with init=1, weights 2/1 -> state=1.
//     Drop init -> state=2.
//  2. D0 holds 0x01,0x02,0x03; D1 holds 0x21,0x22; out_ready=1.
//     -> output order 0x01,0x02,0x21,0x03,0x22; first out_valid 2 cycles after first D0_pop.
//  3. As test 2 but out_ready=0 after the first word -> at most 2 pops beyond the accepted word.
//     out_data holds steady. No pop while the buffer plus in-flight count is 2. Resume -> no loss, no duplicates.
//  4. Weights 0/3, both FIFOs non-empty -> only D1_pop pulses. D0 never popped. Returns to IDLE when D1 is empty.
//  5. error_d1=1 for 1 cycle mid-burst -> state=4 and sched_error=1 the next cycle; pops 0.
//     The buffered word still drains. Stays in ERROR until reset.
//  6. reset pulse during a sustained burst -> out_valid=0, state=0 after the edge; no pop during reset.
//     After re-init, the remaining FIFO words come out in order.

Source files
------------

// File: rtl/full_logic_pkg.sv
// Shared definitions for the full_logic destination-FIFO pop scheduler:
// lifecycle state encoding, default widths and source identifiers.
package full_logic_pkg;

  localparam int DATA_WIDTH_DEF   = 6;
  localparam int WEIGHT_WIDTH_DEF = 3;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

endpackage

// File: rtl/full_logic_skid2.sv
// Two-entry FIFO-ordered output buffer. entry0 is always the head word;
// a pop shifts entry1 forward. The scheduler guarantees it never pushes
// into a full buffer that is not being popped in the same cycle.
module full_logic_skid2 #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry0_q;
  logic [WIDTH-1:0] entry1_q;
  logic [1:0]       count_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop & (count_q != 2'd0);
  assign do_push = push & ((count_q != 2'd2) | do_pop);

  // Buffer storage and occupancy, updated on push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the two entries are reset as well as the count, because the head
      // entry drives out_data directly and must read 0 after reset.
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments here let entry0 take entry1's old value
      // while entry1 is overwritten in the same edge.
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) entry0_q <= push_data;
          else                 entry1_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          entry0_q <= entry1_q;
          count_q  <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            entry0_q <= push_data;
          end else begin
            entry0_q <= entry1_q;
            entry1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign head  = entry0_q;

endmodule

// File: rtl/full_logic_pop_scheduler.sv
// Drains destination FIFOs D0/D1 into one valid/ready stream using weighted
// round-robin. Pops are issued combinationally from registered state; the
// popped word arrives one cycle later and is captured into a 2-entry buffer.
module full_logic_pop_scheduler
  import full_logic_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight_d0,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight_d1,
  input  logic                    empty_d0,
  input  logic                    empty_d1,
  input  logic [DATA_WIDTH-1:0]   data_out_d0,
  input  logic [DATA_WIDTH-1:0]   data_out_d1,
  input  logic                    error_d0,
  input  logic                    error_d1,
  input  logic                    out_ready,
  output logic                    D0_pop,
  output logic                    D1_pop,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_src,
  output logic                    out_valid,
  output logic [2:0]              state,
  output logic                    sched_error
);

  state_t                  state_q;
  state_t                  state_d;
  logic [WEIGHT_WIDTH-1:0] weight_d0_q;
  logic [WEIGHT_WIDTH-1:0] weight_d1_q;
  logic                    grant_q;
  logic [WEIGHT_WIDTH-1:0] burst_cnt_q;
  logic                    inflight_q;
  logic                    inflight_src_q;

  logic                    avail_d0;
  logic                    avail_d1;
  logic                    cur_avail;
  logic                    oth_avail;
  logic [WEIGHT_WIDTH-1:0] cur_weight;
  logic                    eff_grant;
  logic [WEIGHT_WIDTH-1:0] eff_cnt;
  logic                    accept;
  logic [2:0]              occupancy;
  logic                    room;
  logic                    pop_req;
  logic                    pop_any;
  logic [1:0]              buf_count;
  logic [DATA_WIDTH:0]     buf_head;
  logic [DATA_WIDTH:0]     capture_word;

  // A FIFO is a pop candidate only when enabled (weight != 0) and non-empty.
  assign avail_d0  = (weight_d0_q != '0) & ~empty_d0;
  assign avail_d1  = (weight_d1_q != '0) & ~empty_d1;
  assign out_valid = (buf_count != 2'd0);
  assign accept    = out_valid & out_ready;
  // Words already owed to the buffer after this cycle's hand-off.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, accept};
  assign room      = (occupancy < 3'd2);

  // WRR: keep the grant while the current FIFO is usable and under its weight,
  // otherwise hand over to the other FIFO; the burst restarts either way.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    cur_avail  = (grant_q == SRC_D1) ? avail_d1 : avail_d0;
    oth_avail  = (grant_q == SRC_D1) ? avail_d0 : avail_d1;
    cur_weight = (grant_q == SRC_D1) ? weight_d1_q : weight_d0_q;
    eff_grant  = grant_q;
    eff_cnt    = burst_cnt_q;
    if (!(cur_avail && (burst_cnt_q < cur_weight))) begin
      eff_cnt = '0;
      if (oth_avail) eff_grant = ~grant_q;
    end
  end

  assign pop_req = ((eff_grant == SRC_D1) ? avail_d1 : avail_d0) & room;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  // FSM next-state logic; a FIFO error overrides everything once out of RESET.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT: begin
        if (!init) begin
          state_d = ((weight_d0_q == '0) && (weight_d1_q == '0)) ? ST_ERROR : ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (init)                       state_d = ST_INIT;
        else if (avail_d0 || avail_d1)  state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!avail_d0 && !avail_d1 && !inflight_q && (buf_count == 2'd0)) state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
    if ((state_q != ST_RESET) && (error_d0 || error_d1)) state_d = ST_ERROR;
  end

  // FSM outputs: pops only in ACTIVE and never while reset is asserted.
  always_comb begin
    D0_pop      = 1'b0;
    D1_pop      = 1'b0;
    sched_error = (state_q == ST_ERROR);
    if ((state_q == ST_ACTIVE) && !reset && pop_req) begin
      if (eff_grant == SRC_D1) D1_pop = 1'b1;
      else                     D0_pop = 1'b1;
    end
  end

  assign pop_any = D0_pop | D1_pop;

  // Burst weights, latched on every INIT cycle with init held high.
  always_ff @(posedge clk) begin
    if (reset) begin
      weight_d0_q <= WEIGHT_WIDTH'(1);
      weight_d1_q <= WEIGHT_WIDTH'(1);
    end else if ((state_q == ST_INIT) && init) begin
      weight_d0_q <= cfg_weight_d0;
      weight_d1_q <= cfg_weight_d1;
    end
  end

  // Grant and burst counter advance only while draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= SRC_D0;
      burst_cnt_q <= '0;
    end else if (state_q == ST_ACTIVE) begin
      grant_q     <= eff_grant;
      burst_cnt_q <= pop_any ? (eff_cnt + WEIGHT_WIDTH'(1)) : eff_cnt;
    end
  end

  // In-flight tracker: the FIFO read data is valid the cycle after a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q     <= 1'b0;
      inflight_src_q <= SRC_D0;
    end else begin
      inflight_q     <= pop_any;
      inflight_src_q <= D1_pop;
    end
  end

  assign capture_word = {inflight_src_q, (inflight_src_q == SRC_D1) ? data_out_d1 : data_out_d0};

  full_logic_skid2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (capture_word),
    .pop       (accept),
    .count     (buf_count),
    .head      (buf_head)
  );

  assign out_src  = buf_head[DATA_WIDTH];
  assign out_data = buf_head[DATA_WIDTH-1:0];
  assign state    = state_q;

endmodule

// File: tb/tb_full_logic_pop_scheduler.sv
// Bench for full_logic_pop_scheduler: behavioural models of the D0/D1 FIFOs,
// an ordered scoreboard of expected output words, a lifecycle vector table
// and directed sequences for ordering, backpressure, disable, error, reset.
module tb_full_logic_pop_scheduler;

  localparam int DW = 6;
  localparam int WW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [WW-1:0] cfg_weight_d0;
  logic [WW-1:0] cfg_weight_d1;
  logic          empty_d0;
  logic          empty_d1;
  logic [DW-1:0] data_out_d0;
  logic [DW-1:0] data_out_d1;
  logic          error_d0;
  logic          error_d1;
  logic          out_ready;
  logic          D0_pop;
  logic          D1_pop;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_valid;
  logic [2:0]    state;
  logic          sched_error;

  full_logic_pop_scheduler #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .cfg_weight_d0 (cfg_weight_d0),
    .cfg_weight_d1 (cfg_weight_d1),
    .empty_d0      (empty_d0),
    .empty_d1      (empty_d1),
    .data_out_d0   (data_out_d0),
    .data_out_d1   (data_out_d1),
    .error_d0      (error_d0),
    .error_d1      (error_d1),
    .out_ready     (out_ready),
    .D0_pop        (D0_pop),
    .D1_pop        (D1_pop),
    .out_data      (out_data),
    .out_src       (out_src),
    .out_valid     (out_valid),
    .state         (state),
    .sched_error   (sched_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          ini;
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    logic [2:0]    exp_state;
    logic          exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW:0]   exp_q[$];

  int   cyc = 0;
  int   occ = 0;
  int   acc_total = 0;
  int   pop0_cnt = 0;
  int   first_pop = -1;
  int   first_valid = -1;
  logic p0;
  logic p1;
  logic acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock cycle: sample DUT at the falling edge, then advance the FIFO models.
  task automatic tick();
    @(negedge clk);
    p0  = D0_pop;
    p1  = D1_pop;
    acc = out_valid & out_ready;
    if (reset) check("no_pop_in_reset", {30'd0, p0, p1}, 32'd0);
    if (p0 | p1) begin
      check("single_pop", {31'd0, p0 & p1}, 32'd0);
      check("pop_room", {31'd0, (occ - int'(acc)) < 2}, 32'd1);
    end
    if (p0 && first_pop < 0) first_pop = cyc;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (acc) begin
      acc_total++;
      if (exp_q.size() == 0) check("unexpected_word", exp_q.size(), 32'd1);
      else                   check("sb_word", {25'd0, out_src, out_data}, {25'd0, exp_q.pop_front()});
    end
    if (p0) pop0_cnt++;
    occ = occ + int'(p0 | p1) - int'(acc);
    if (reset) occ = 0;
    @(posedge clk);
    #1;
    if (p0) begin
      if (q0.size() == 0) check("pop_empty_d0", q0.size(), 32'd1);
      else                data_out_d0 = q0.pop_front();
    end
    if (p1) begin
      if (q1.size() == 0) check("pop_empty_d1", q1.size(), 32'd1);
      else                data_out_d1 = q1.pop_front();
    end
    empty_d0 = (q0.size() == 0);
    empty_d1 = (q1.size() == 0);
    cyc++;
  endtask

  task automatic load(input logic src, input logic [DW-1:0] w);
    if (src) q1.push_back(w);
    else     q0.push_back(w);
    exp_q.push_back({src, w});
    empty_d0 = (q0.size() == 0);
    empty_d1 = (q1.size() == 0);
  endtask

  task automatic run_until_idle(input int max_cycles, input string name);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && (state == 3'd2) && !out_valid;
    end
    check({name, "_drained"}, {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset_init(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
    reset = 1'b1;
    init  = 1'b0;
    tick();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    reset         = 1'b0;
    init          = 1'b1;
    cfg_weight_d0 = w0;
    cfg_weight_d1 = w1;
    tick();
    tick();
    init = 1'b0;
    tick();
    check("init_to_idle", {29'd0, state}, 32'd2);
  endtask

  initial begin
    vec_t     vecs[13];
    logic [DW:0] held;

    vecs[0]  = '{1'b1, 1'b0, 3'd1, 3'd1, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd1, 3'd1, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 3'd1, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'd2, 3'd1, 3'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 3'd2, 3'd1, 3'd2, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'd0, 3'd0, 3'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'd0, 3'd0, 3'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 3'd0, 3'd0, 3'd4, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 3'd2, 3'd1, 3'd4, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'd2, 3'd1, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'd2, 3'd1, 3'd1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'd2, 3'd1, 3'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'd2, 3'd1, 3'd2, 1'b0};

    reset         = 1'b1;
    init          = 1'b0;
    cfg_weight_d0 = 3'd1;
    cfg_weight_d1 = 3'd1;
    empty_d0      = 1'b1;
    empty_d1      = 1'b1;
    data_out_d0   = '0;
    data_out_d1   = '0;
    error_d0      = 1'b0;
    error_d1      = 1'b0;
    out_ready     = 1'b0;

    // Lifecycle table: reset, init latching, all-disabled error, recovery.
    for (int i = 0; i < 13; i++) begin
      reset         = vecs[i].rst;
      init          = vecs[i].ini;
      cfg_weight_d0 = vecs[i].w0;
      cfg_weight_d1 = vecs[i].w1;
      tick();
      check($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, vecs[i].exp_state});
      check($sformatf("vec%0d_sched_error", i), {31'd0, sched_error}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("vec%0d_out_word", i), {25'd0, out_src, out_data}, 32'd0);
    end

    // Weighted order 2/1 with free-flowing output.
    do_reset_init(3'd2, 3'd1);
    out_ready   = 1'b1;
    first_pop   = -1;
    first_valid = -1;
    load(1'b0, 6'h01); load(1'b0, 6'h02); load(1'b1, 6'h21);
    load(1'b0, 6'h03); load(1'b1, 6'h22);
    run_until_idle(40, "t2");
    check("t2_latency", 32'(first_valid - first_pop), 32'd2);
    check("t2_fifos_empty", 32'(q0.size() + q1.size()), 32'd0);

    // Backpressure after the first word: head holds, at most two words owed.
    do_reset_init(3'd2, 3'd1);
    out_ready = 1'b1;
    acc_total = 0;
    load(1'b0, 6'h01); load(1'b0, 6'h02); load(1'b1, 6'h21);
    load(1'b0, 6'h03); load(1'b1, 6'h22);
    for (int i = 0; i < 20 && acc_total == 0; i++) tick();
    check("t3_first_accept", acc_total, 32'd1);
    out_ready = 1'b0;
    held      = {out_src, out_data};
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t3_hold_word", {25'd0, out_src, out_data}, {25'd0, held});
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    check("t3_stall_occupancy", occ, 32'd2);
    out_ready = 1'b1;
    run_until_idle(40, "t3");
    check("t3_accept_total", acc_total, 32'd5);

    // D0 disabled: only D1 is drained, D0 contents untouched.
    do_reset_init(3'd0, 3'd3);
    out_ready = 1'b1;
    pop0_cnt  = 0;
    q0.push_back(6'h05);
    q0.push_back(6'h06);
    load(1'b1, 6'h31); load(1'b1, 6'h32); load(1'b1, 6'h33); load(1'b1, 6'h34);
    run_until_idle(40, "t4");
    check("t4_d0_pops", pop0_cnt, 32'd0);
    check("t4_d0_left", q0.size(), 32'd2);
    q0.delete();
    empty_d0 = 1'b1;

    // FIFO error mid-burst: sticky ERROR, no further pops, buffer drains.
    do_reset_init(3'd2, 3'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) load(1'b0, 6'(8'h10 + i));
    for (int i = 0; i < 4; i++) tick();
    error_d1 = 1'b1;
    tick();
    error_d1 = 1'b0;
    check("t5_state", {29'd0, state}, 32'd4);
    check("t5_sched_error", {31'd0, sched_error}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_no_pop", {30'd0, p0, p1}, 32'd0);
    end
    check("t5_drained_valid", {31'd0, out_valid}, 32'd0);
    check("t5_drained_occ", occ, 32'd0);
    check("t5_unpopped", exp_q.size(), q0.size());
    check("t5_sticky", {29'd0, state}, 32'd4);

    // Reset during a sustained burst, then re-init and drain the remainder.
    do_reset_init(3'd2, 3'd1);
    q0.delete();
    out_ready = 1'b1;
    acc_total = 0;
    for (int i = 0; i < 8; i++) load(1'b0, 6'(8'h20 + i));
    for (int i = 0; i < 20 && acc_total < 2; i++) tick();
    check("t6_started", {31'd0, acc_total >= 2}, 32'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_state", {29'd0, state}, 32'd0);
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    foreach (q0[i]) exp_q.push_back({1'b0, q0[i]});
    reset = 1'b0;
    init  = 1'b1;
    tick();
    tick();
    init = 1'b0;
    run_until_idle(60, "t6");
    check("t6_fifo_empty", q0.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
